sid_audio_decim: RTL and testbench

Downstream stage of the SID core. It takes the two 18-bit signed audio outputs, sampled once per ce_1m tick, and box-car averages them over DECIM ticks. The result is scaled, saturated to 16-bit signed, and handed to the audio mixer/codec path through a 2-entry valid/ready FIFO. Dropped samples are counted for debug.

---
 rtl/sid_audio_decim.sv | 148 ++++++++++++++
 tb/tb_sid_audio_decim.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sid_audio_decim.sv
// SID audio decimator: box-car average over DECIM ce ticks, gain,
// saturate to 16 bits, and queue stereo samples in a 2-deep FIFO.
module sid_audio_decim #(
  parameter int DECIM      = 21,
  parameter int GAIN_SHIFT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce_1m,
  input  logic signed [17:0] audio_l,
  input  logic signed [17:0] audio_r,
  input  logic               mute,
  output logic signed [15:0] out_l,
  output logic signed [15:0] out_r,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         drop_cnt
);

  localparam int CW    = $clog2(DECIM);
  localparam int AW    = 18 + CW;
  localparam int PW    = AW + 26;
  localparam int RECIP = (2**24 + DECIM / 2) / DECIM;
  localparam logic signed [PW-1:0] RECIP_S = PW'(RECIP);
  localparam logic signed [PW-1:0] RND     = PW'(2**23);

  logic [CW-1:0]        cnt;
  logic signed [AW-1:0] acc_l, acc_r;
  logic signed [AW-1:0] in_l, in_r;
  logic signed [AW-1:0] sum_l, sum_r;
  logic signed [PW-1:0] sx_l, sx_r;
  logic signed [PW-1:0] p_l, p_r;
  logic signed [17:0]   mean_l, mean_r;
  logic signed [15:0]   s_l, s_r;
  logic                 v0, v1, v2;

  assign in_l = audio_l;
  assign in_r = audio_r;
  assign sx_l = sum_l;
  assign sx_r = sum_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      acc_l <= '0;
      acc_r <= '0;
      sum_l <= '0;
      sum_r <= '0;
      v0    <= 1'b0;
    end else begin
      v0 <= 1'b0;
      if (ce_1m) begin
        if (cnt == CW'(DECIM - 1)) begin
          sum_l <= acc_l + in_l;
          sum_r <= acc_r + in_r;
          acc_l <= '0;
          acc_r <= '0;
          cnt   <= '0;
          v0    <= 1'b1;
        end else begin
          acc_l <= acc_l + in_l;
          acc_r <= acc_r + in_r;
          cnt   <= cnt + 1'b1;
        end
      end
    end
  end

  // Multiply by the rounded reciprocal instead of dividing.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_l    <= '0;
      p_r    <= '0;
      mean_l <= '0;
      mean_r <= '0;
      v1     <= 1'b0;
      v2     <= 1'b0;
    end else begin
      p_l    <= sx_l * RECIP_S + RND;
      p_r    <= sx_r * RECIP_S + RND;
      v1     <= v0;
      mean_l <= p_l[24 +: 18];
      mean_r <= p_r[24 +: 18];
      v2     <= v1;
    end
  end

  logic unused_p;
  assign unused_p = ^{p_l[23:0], p_l[PW-1:42],
                      p_r[23:0], p_r[PW-1:42]};

  function automatic logic signed [15:0] scale(
    input logic signed [17:0] m
  );
    logic signed [20:0] e;
    logic signed [20:0] g;
    e = m;
    g = (e <<< GAIN_SHIFT) >>> 2;
    if (g > 21'sd32767)
      return 16'sh7fff;
    else if (g < -21'sd32768)
      return 16'sh8000;
    else
      return g[15:0];
  endfunction

  assign s_l = mute ? '0 : scale(mean_l);
  assign s_r = mute ? '0 : scale(mean_r);

  logic [15:0] mem_l [2];
  logic [15:0] mem_r [2];
  logic        rd;
  logic [1:0]  count;
  logic        pop, full, wr_en, drop;
  logic        wr_idx;

  assign out_valid = (count != 2'd0);
  assign out_l     = out_valid ? mem_l[rd] : '0;
  assign out_r     = out_valid ? mem_r[rd] : '0;
  assign pop       = out_valid & out_ready;
  assign full      = (count == 2'd2);
  assign wr_en     = v2 & (~full | pop);
  assign drop      = v2 & full & ~pop;
  // Full with pop reuses the slot being freed at rd.
  assign wr_idx    = rd ^ count[0];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_l[wr_idx] <= s_l;
      mem_r[wr_idx] <= s_r;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd       <= 1'b0;
      count    <= 2'd0;
      drop_cnt <= 8'd0;
    end else begin
      if (pop)
        rd <= ~rd;
      count <= count + {1'b0, wr_en} - {1'b0, pop};
      if (drop && drop_cnt != 8'hff)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_sid_audio_decim.sv
// Scoreboard bench for sid_audio_decim: unity-gain and GAIN_SHIFT=0
// instances fed the same audio, expected samples queued per window.
module tb_sid_audio_decim;

  localparam int DECIM = 21;

  typedef struct {
    int l;
    int r;
  } pair_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ce_1m = 1'b0;
  logic signed [17:0] audio_l = '0;
  logic signed [17:0] audio_r = '0;
  logic              mute = 1'b0;
  logic              out_ready = 1'b0;
  logic              ready0 = 1'b1;
  logic signed [15:0] out_l, out_r, g0_l, g0_r;
  logic              out_valid, g0_valid;
  logic [7:0]        drop_cnt, g0_drop;

  int    n_tests = 0;
  int    n_fail  = 0;
  pair_t q[$];
  pair_t q0[$];
  int    acc_l = 0;
  int    acc_r = 0;
  int    n_tick = 0;
  int    exp_drop = 0;

  always #5 clk = ~clk;

  sid_audio_decim #(.DECIM(DECIM), .GAIN_SHIFT(2)) dut (
    .clk(clk), .reset(reset), .ce_1m(ce_1m),
    .audio_l(audio_l), .audio_r(audio_r), .mute(mute),
    .out_l(out_l), .out_r(out_r), .out_valid(out_valid),
    .out_ready(out_ready), .drop_cnt(drop_cnt)
  );

  sid_audio_decim #(.DECIM(DECIM), .GAIN_SHIFT(0)) dut_g0 (
    .clk(clk), .reset(reset), .ce_1m(ce_1m),
    .audio_l(audio_l), .audio_r(audio_r), .mute(mute),
    .out_l(g0_l), .out_r(g0_r), .out_valid(g0_valid),
    .out_ready(ready0), .drop_cnt(g0_drop)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int model(input int sum, input int gs, input bit m);
    int mean;
    int g;
    if (m)
      return 0;
    mean = int'($floor(real'(sum) / DECIM + 0.5));
    g = (mean * (1 << gs)) >>> 2;
    if (g > 32767)
      g = 32767;
    if (g < -32768)
      g = -32768;
    return g;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int l, input int r, input bit lat);
    bit    fin;
    pair_t e;
    ce_1m   = 1'b1;
    audio_l = 18'(l);
    audio_r = 18'(r);
    acc_l  += l;
    acc_r  += r;
    n_tick++;
    fin = (n_tick == DECIM);
    if (fin) begin
      e.l = model(acc_l, 2, mute);
      e.r = model(acc_r, 2, mute);
      if (!out_ready && q.size() >= 2) begin
        if (exp_drop < 255)
          exp_drop++;
      end else begin
        q.push_back(e);
      end
      e.l = model(acc_l, 0, mute);
      e.r = model(acc_r, 0, mute);
      q0.push_back(e);
      acc_l  = 0;
      acc_r  = 0;
      n_tick = 0;
    end
    @(posedge clk);
    #1;
    ce_1m = 1'b0;
    if (lat && fin) begin
      idle(2);
      chk("lat3_valid", int'(out_valid), 0);
      idle(1);
      chk("lat4_valid", int'(out_valid), 1);
    end else begin
      idle(2);
    end
  endtask

  task automatic window(input int l, input int r, input bit lat);
    for (int i = 0; i < DECIM; i++)
      send(l, r, lat);
  endtask

  always @(negedge clk) begin
    pair_t e;
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("extra_out", int'(out_valid), 0);
        end else begin
          e = q.pop_front();
          chk("out_l", out_l, e.l);
          chk("out_r", out_r, e.r);
        end
      end
      if (g0_valid && ready0) begin
        if (q0.size() == 0) begin
          chk("extra_g0", int'(g0_valid), 0);
        end else begin
          e = q0.pop_front();
          chk("g0_l", g0_l, e.l);
          chk("g0_r", g0_r, e.r);
        end
      end
    end
  end

  initial begin
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_l", out_l, 0);
    chk("rst_r", out_r, 0);
    chk("rst_drop", drop_cnt, 0);
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    window(1000, -500, 1'b1);
    window(1000, -500, 1'b0);
    window(1000, -500, 1'b0);
    idle(8);

    for (int i = 0; i < DECIM; i++)
      send(i, -1, 1'b0);
    idle(8);

    window(131071, -131072, 1'b0);
    window(-40, 77, 1'b0);
    idle(8);

    out_ready = 1'b0;
    window(100, 1, 1'b0);
    window(200, 2, 1'b0);
    window(300, 3, 1'b0);
    idle(6);
    chk("hold_valid", int'(out_valid), 1);
    chk("hold_l", out_l, 100);
    chk("hold_r", out_r, 1);
    chk("drop_cnt", drop_cnt, exp_drop);
    out_ready = 1'b1;
    idle(6);
    chk("drain_valid", int'(out_valid), 0);

    mute = 1'b1;
    window(1000, -500, 1'b0);
    for (int i = 0; i < 10; i++)
      send(1000, -500, 1'b0);
    mute = 1'b0;
    for (int i = 0; i < 11; i++)
      send(1000, -500, 1'b0);
    idle(8);
    chk("mute_drop", drop_cnt, exp_drop);

    out_ready = 1'b0;
    window(2000, 2000, 1'b0);
    idle(6);
    chk("pend_valid", int'(out_valid), 1);
    for (int i = 0; i < 10; i++)
      send(5000, 5000, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    q0.delete();
    acc_l    = 0;
    acc_r    = 0;
    n_tick   = 0;
    exp_drop = 0;
    chk("post_rst_valid", int'(out_valid), 0);
    chk("post_rst_drop", drop_cnt, exp_drop);
    out_ready = 1'b1;
    window(300, -7, 1'b1);
    idle(8);

    chk("q_left", q.size(), 0);
    chk("q0_left", q0.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
